mem_port_arbiter: RTL

- Shares one single-ported unified memory between the instruction-fetch requester (IF) and the load/store requester (LS) of the RV32I core.
- Serialises accesses with a small FSM and round-robin arbitration.
- Drives a req/ready memory interface and returns a one-cycle ack plus registered read data to each requester.
- Sits between the fetch/load-store stages and the memory model; the core stalls on a requester until it sees that requester's ack.

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_port_arbiter_rr_pick2.sv | 23 ++
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the IF/LS memory port arbiter: FSM encodings,
// grant identifiers and default bus widths.
package mem_port_arbiter_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACC_IF = 2'd1;
  localparam logic [1:0] ST_ACC_LS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // Grant identifiers (also the bit index of each requester in req[1:0])
  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_LS = 1'b1;

  // Default bus widths
  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin chooser. On a tie the requester that
// did not win last time is picked, so neither side can starve.
module rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // Pick the single requester, or the one opposite to last on a tie
  always_comb begin
    gnt_valid = |req;
    gnt_id    = GNT_IF;
    if (req[GNT_IF] && req[GNT_LS]) begin
      gnt_id = ~last;
    end else if (req[GNT_LS]) begin
      gnt_id = GNT_LS;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch (IF) and load/store
// (LS) requesters. One access at a time: IDLE arbitrates, ACC_x holds the
// memory request until mem_ready, RESP separates the ack from the next grant.
//
// Handshakes: a requester raises its req with stable payload and holds it
// until its one-cycle ack; mem_req is held with frozen mem_* outputs until
// mem_ready is seen high on a rising edge, and mem_rdata is sampled on
// that same edge. mem_ready outside ACC_x is ignored.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_ack,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [AW-1:0]   ls_addr,
  input  logic [DW-1:0]   ls_wdata,
  input  logic [DW/8-1:0] ls_be,
  output logic [DW-1:0]   ls_rdata,
  output logic            ls_ack,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_ready,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy,
  output logic [1:0]      dbg_state
);

  localparam int BW = DW / 8;

  logic [1:0]    r_state;
  logic          r_last;
  logic          r_mem_req;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [BW-1:0] r_mem_be;
  logic          r_if_ack;
  logic          r_ls_ack;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_ls_rdata;

  logic [1:0]    w_req;
  logic          w_gnt_valid;
  logic          w_gnt_id;

  assign w_req = {ls_req, if_req};

  rr_pick2 u_pick (
    .req       (w_req),
    .last      (r_last),
    .gnt_valid (w_gnt_valid),
    .gnt_id    (w_gnt_id)
  );

  // FSM, memory request registers, acks and returned read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_last      <= GNT_IF;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_if_ack    <= 1'b0;
      r_ls_ack    <= 1'b0;
      r_if_rdata  <= '0;
      r_ls_rdata  <= '0;
    end else begin
      // Acks are single-cycle pulses unless set below
      r_if_ack <= 1'b0;
      r_ls_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_valid) begin
            r_last    <= w_gnt_id;
            r_mem_req <= 1'b1;
            if (w_gnt_id == GNT_LS) begin
              r_state     <= ST_ACC_LS;
              r_mem_we    <= ls_we;
              r_mem_addr  <= ls_addr;
              r_mem_wdata <= ls_wdata;
              r_mem_be    <= ls_be;
            end else begin
              r_state     <= ST_ACC_IF;
              r_mem_we    <= 1'b0;
              r_mem_addr  <= if_addr;
              r_mem_wdata <= '0;
              r_mem_be    <= '1;
            end
          end
        end
        ST_ACC_IF: begin
          if (mem_ready) begin
            r_mem_req  <= 1'b0;
            r_if_ack   <= 1'b1;
            r_if_rdata <= mem_rdata;
            r_state    <= ST_RESP;
          end
        end
        ST_ACC_LS: begin
          if (mem_ready) begin
            r_mem_req <= 1'b0;
            r_ls_ack  <= 1'b1;
            // Stores keep the previous load data
            if (!r_mem_we) begin
              r_ls_rdata <= mem_rdata;
            end
            r_state <= ST_RESP;
          end
        end
        default: begin
          // RESP: no arbitration here, so a just-acked req is not re-granted
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;
  assign if_ack    = r_if_ack;
  assign ls_ack    = r_ls_ack;
  assign if_rdata  = r_if_rdata;
  assign ls_rdata  = r_ls_rdata;
  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;

endmodule
